// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, addresses the combinational instruction memory and holds
// one fetched instruction for decode. Optional misaligned-redirect fault: FETCH_ALIGN_CHECK_EN.
module fetch_unit #(
    parameter int unsigned ADDR_W    = 11,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_instr,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [31:0]       out_pc,
    output logic              fault
);

    logic [31:0] r_pc, r_pc_d;
    logic        r_out_valid, r_out_valid_d;
    logic [31:0] r_out_instr, r_out_instr_d;
    logic [31:0] r_out_pc, r_out_pc_d;
    logic        r_fault, r_fault_d;
    logic        w_load;
    logic        w_misalign;

`ifdef FETCH_ALIGN_CHECK_EN
    assign w_misalign = redirect_valid & (redirect_pc[1:0] != 2'b00);
`else
    // Low target bits are dropped silently in this build.
    logic w_unused_lo;
    assign w_unused_lo = ^redirect_pc[1:0];
    assign w_misalign  = 1'b0;
`endif

    assign w_load = en & ~r_fault & ~redirect_valid & (~r_out_valid | out_ready);

    always_comb begin
        r_pc_d        = r_pc;
        r_out_valid_d = r_out_valid;
        r_out_instr_d = r_out_instr;
        r_out_pc_d    = r_out_pc;
        r_fault_d     = r_fault | w_misalign;
        if (redirect_valid) begin
            // Flush wins even over a same-cycle handshake; decode still sees it as consumed.
            r_pc_d        = {redirect_pc[31:2], 2'b00};
            r_out_valid_d = 1'b0;
            r_out_instr_d = NOP_INSTR;
        end else if (w_load) begin
            r_out_instr_d = imem_instr;
            r_out_pc_d    = r_pc;
            r_out_valid_d = 1'b1;
            r_pc_d        = r_pc + 32'd4;
        end else if (r_out_valid && out_ready) begin
            r_out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc        <= RESET_PC;
            r_out_valid <= 1'b0;
            r_out_instr <= NOP_INSTR;
            r_out_pc    <= 32'h0000_0000;
            r_fault     <= 1'b0;
        end else begin
            r_pc        <= r_pc_d;
            r_out_valid <= r_out_valid_d;
            r_out_instr <= r_out_instr_d;
            r_out_pc    <= r_out_pc_d;
            r_fault     <= r_fault_d;
        end
    end

    assign imem_addr = r_pc[ADDR_W+1:2];
    assign out_valid = r_out_valid;
    assign out_instr = r_out_instr;
    assign out_pc    = r_out_pc;
    assign fault     = r_fault;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed stimulus pushes expected (pc, instr) pairs, a negedge
// monitor pops them on every accepted handshake.
module tb_fetch_unit;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } item_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [10:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        fault;

    logic [31:0] mem [0:2047];
    item_t       exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    assign imem_instr = mem[imem_addr];

    fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .en             (en),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .fault          (fault)
    );

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endfunction

    function automatic void push(input logic [31:0] pc, input logic [31:0] instr);
        item_t it;
        it.pc    = pc;
        it.instr = instr;
        exp_q.push_back(it);
    endfunction

    // Monitor: the handshake seen here completes at the following rising edge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_unexpected: got pc=%h instr=%h, expected no output", out_pc,
                         out_instr);
            end else begin
                item_t e;
                e = exp_q.pop_front();
                chk("sb_pc", out_pc, e.pc);
                chk("sb_instr", out_instr, e.instr);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Asserts reset between edges and checks that the stage clears without waiting for a clock.
    task automatic async_reset();
        #3;
        rst = 1'b1;
        en = 1'b0;
        out_ready = 1'b0;
        redirect_valid = 1'b0;
        #1;
        chk("rst_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_instr", out_instr, 32'h0000_0013);
        chk("rst_out_pc", out_pc, 32'd0);
        chk("rst_addr", {21'b0, imem_addr}, 32'd0);
        chk("rst_fault", {31'b0, fault}, 32'd0);
        chk("rst_queue_empty", exp_q.size(), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got no finish, expected finish before 100000");
        $fatal(1, "timeout");
    end

    initial begin
        for (int k = 0; k < 2048; k++) mem[k] = 32'h1000_0000 | k;
        mem[0] = 32'h0000_0013;
        mem[1] = 32'h0000_0023;
        mem[2] = 32'h0000_0012;

        rst = 1'b1;
        en = 1'b0;
        out_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'd0;
        tick();
        chk("init_valid", {31'b0, out_valid}, 32'd0);
        chk("init_instr", out_instr, 32'h0000_0013);
        chk("init_out_pc", out_pc, 32'd0);
        chk("init_fault", {31'b0, fault}, 32'd0);

        // Streaming at one instruction per cycle.
        rst = 1'b0;
        en = 1'b1;
        out_ready = 1'b1;
        chk("s_addr0", {21'b0, imem_addr}, 32'd0);
        push(32'd0, 32'h0000_0013);
        push(32'd4, 32'h0000_0023);
        push(32'd8, 32'h0000_0012);
        tick();
        chk("s_valid_first", {31'b0, out_valid}, 32'd1);
        chk("s_addr1", {21'b0, imem_addr}, 32'd1);
        tick();
        chk("s_addr2", {21'b0, imem_addr}, 32'd2);
        tick();
        chk("s_addr3", {21'b0, imem_addr}, 32'd3);
        en = 1'b0;
        tick();
        chk("s_drop_valid", {31'b0, out_valid}, 32'd0);
        tick();
        chk("s_frozen_addr", {21'b0, imem_addr}, 32'd3);

        // Backpressure, then en=0 after two fetches.
        async_reset();
        en = 1'b1;
        out_ready = 1'b0;
        push(32'd0, 32'h0000_0013);
        push(32'd4, 32'h0000_0023);
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("bp_valid", {31'b0, out_valid}, 32'd1);
            chk("bp_pc", out_pc, 32'd0);
            chk("bp_instr", out_instr, 32'h0000_0013);
            chk("bp_addr", {21'b0, imem_addr}, 32'd1);
            tick();
        end
        out_ready = 1'b1;
        tick();
        en = 1'b0;
        chk("bp_release_pc", out_pc, 32'd4);
        tick();
        chk("en0_valid", {31'b0, out_valid}, 32'd0);
        chk("en0_addr", {21'b0, imem_addr}, 32'd2);
        tick();
        chk("en0_frozen", {21'b0, imem_addr}, 32'd2);
        en = 1'b1;
        push(32'd8, 32'h0000_0012);
        tick();
        en = 1'b0;
        chk("resume_pc", out_pc, 32'd8);
        tick();

        // Redirect with a live output: one bubble, then the target.
        async_reset();
        en = 1'b1;
        out_ready = 1'b1;
        push(32'd0, 32'h0000_0013);
        push(32'd4, 32'h0000_0023);
        push(32'd8, 32'h0000_0012);
        tick();
        tick();
        chk("rd_pre_pc", out_pc, 32'd4);
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0008;
        tick();
        redirect_valid = 1'b0;
        chk("rd_bubble", {31'b0, out_valid}, 32'd0);
        chk("rd_bubble_instr", out_instr, 32'h0000_0013);
        chk("rd_addr", {21'b0, imem_addr}, 32'd2);
        tick();
        chk("rd_target_valid", {31'b0, out_valid}, 32'd1);
        chk("rd_target_pc", out_pc, 32'd8);
        chk("rd_target_instr", out_instr, 32'h0000_0012);
        en = 1'b0;
        tick();
        chk("rd_drain", {31'b0, out_valid}, 32'd0);

        // Redirect honoured with en=0; upper PC bits alias into the memory.
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_2004;
        tick();
        redirect_valid = 1'b0;
        chk("alias_addr", {21'b0, imem_addr}, 32'd1);
        chk("alias_valid", {31'b0, out_valid}, 32'd0);
        en = 1'b1;
        push(32'h0000_2004, 32'h0000_0023);
        tick();
        en = 1'b0;
        tick();

        // PC wraps from the top of the address space to zero.
        en = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        push(32'hFFFF_FFFC, 32'h1000_07FF);
        push(32'h0000_0000, 32'h0000_0013);
        tick();
        redirect_valid = 1'b0;
        chk("wrap_addr_top", {21'b0, imem_addr}, 32'h7FF);
        tick();
        chk("wrap_addr_zero", {21'b0, imem_addr}, 32'd0);
        tick();
        en = 1'b0;
        tick();
        chk("wrap_drain", {31'b0, out_valid}, 32'd0);

        // Reset mid-stream with an unconsumed output pending.
        async_reset();
        en = 1'b1;
        out_ready = 1'b0;
        tick();
        chk("mid_valid", {31'b0, out_valid}, 32'd1);
        async_reset();
        en = 1'b1;
        out_ready = 1'b1;
        push(32'd0, 32'h0000_0013);
        tick();
        chk("restart_pc", out_pc, 32'd0);
        en = 1'b0;
        tick();

        // Misaligned redirect.
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0006;
        tick();
        redirect_valid = 1'b0;
        chk("mis_addr", {21'b0, imem_addr}, 32'd1);
`ifdef FETCH_ALIGN_CHECK_EN
        chk("mis_fault", {31'b0, fault}, 32'd1);
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mis_blocked", {31'b0, out_valid}, 32'd0);
            chk("mis_sticky", {31'b0, fault}, 32'd1);
        end
        async_reset();
`else
        chk("mis_no_fault", {31'b0, fault}, 32'd0);
        en = 1'b1;
        push(32'd4, 32'h0000_0023);
        tick();
        en = 1'b0;
        chk("mis_pc", out_pc, 32'd4);
        chk("mis_instr", out_instr, 32'h0000_0023);
        tick();
`endif

        tick();
        tick();
        chk("final_queue_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
